// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// Request fields are held stable from dm_req rise until dm_ack; dm_rdata is
// valid in the same cycle as dm_ack.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32
);

  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_be,
    output dm_wdata,
    input  dm_ack,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_be,
    input  dm_wdata,
    output dm_ack,
    output dm_rdata
  );

endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage. Passes ALU results straight through to MEM/WB, or runs
// one load/store on the data memory over a req/ack handshake while stalling
// the upstream pipeline. FSM: IDLE -> BUSY -> DONE -> IDLE.
// Optional feature macro: MEM_TIMEOUT_EN -- aborts a BUSY access after
// TIMEOUT cycles without dm_ack and flags mem_err for one cycle.
module mem_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // From EX/MEM
  input  logic [REG_ADDR_W-1:0] mem_des_addr,
  input  logic                  mem_des_exist,
  input  logic [DATA_W-1:0]     mem_des_data,
  input  logic [3:0]            mem_op,
  input  logic [DATA_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  // Data-memory bus
  mem_stage_if.master           dm,
  // Pipeline control / status
  output logic                  stall_mem,
  output logic                  mem_misalign,
  output logic                  mem_err,
  // To MEM/WB
  output logic [REG_ADDR_W-1:0] wb_des_addr,
  output logic                  wb_des_exist,
  output logic [DATA_W-1:0]     wb_des_data
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Decoded view of the incoming instruction
  logic              is_load;
  logic              is_store;
  logic              is_misalign;
  logic [3:0]        acc_be;
  logic [DATA_W-1:0] acc_wdata;
  logic              go;

  // FSM and request registers
  logic [1:0]            state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  // Context of the outstanding access, needed to build the DONE result
  logic [3:0]            op_q, op_d;
  logic [1:0]            lane_q, lane_d;
  logic [REG_ADDR_W-1:0] des_addr_q, des_addr_d;
  logic                  des_exist_q, des_exist_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic              timeout_hit;
  logic              abort;
  logic              op_q_is_load;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] load_val;

  // Decode op into load/store class, alignment check and byte-lane layout
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_misalign = 1'b0;
    acc_be      = 4'b0000;
    acc_wdata   = '0;
    case (mem_op)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        acc_be  = 4'b0001 << mem_addr[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load     = 1'b1;
        is_misalign = mem_addr[0];
        acc_be      = mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        is_load     = 1'b1;
        is_misalign = |mem_addr[1:0];
        acc_be      = 4'b1111;
      end
      OP_SB: begin
        is_store  = 1'b1;
        acc_be    = 4'b0001 << mem_addr[1:0];
        acc_wdata = {4{mem_wdata[7:0]}};
      end
      OP_SH: begin
        is_store    = 1'b1;
        is_misalign = mem_addr[0];
        acc_be      = mem_addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata   = {2{mem_wdata[15:0]}};
      end
      OP_SW: begin
        is_store    = 1'b1;
        is_misalign = |mem_addr[1:0];
        acc_be      = 4'b1111;
        acc_wdata   = mem_wdata;
      end
      default: ;
    endcase
  end

  // An access is launched only for an aligned memory op seen in IDLE
  assign go = (state_q == IDLE) && (is_load || is_store) && !is_misalign;

  // A same-cycle ack takes priority over the timeout
  assign abort = (state_q == BUSY) && !dm.dm_ack && timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // Last BUSY cycle: the count reaches TIMEOUT with this cycle's increment
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // BUSY cycle counter and one-cycle abort flag (err_q is high only in DONE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (go) begin
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
      err_q <= abort;
    end
  end

  assign mem_err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // Next state: launch in IDLE, hold the request until ack/abort, one DONE cycle
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    lane_d      = lane_q;
    des_addr_d  = des_addr_q;
    des_exist_d = des_exist_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d     = BUSY;
          req_d       = 1'b1;
          we_d        = is_store;
          addr_d      = {mem_addr[DATA_W-1:2], 2'b00};
          be_d        = acc_be;
          wdata_d     = acc_wdata;
          op_d        = mem_op;
          lane_d      = mem_addr[1:0];
          des_addr_d  = mem_des_addr;
          des_exist_d = mem_des_exist;
        end
      end
      BUSY: begin
        if (dm.dm_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = dm.dm_rdata;
        end else if (abort) begin
          state_d = DONE;
          req_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and request registers; reset drops dm_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      op_q        <= 4'd0;
      lane_q      <= 2'd0;
      des_addr_q  <= '0;
      des_exist_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      des_addr_q  <= des_addr_d;
      des_exist_q <= des_exist_d;
      rdata_q     <= rdata_d;
    end
  end

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_be    = be_q;
  assign dm.dm_wdata = wdata_q;

  assign op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);

  // Extract and extend the addressed byte/half of the captured load word
  always_comb begin
    case (lane_q)
      2'd0:    byte_v = rdata_q[7:0];
      2'd1:    byte_v = rdata_q[15:8];
      2'd2:    byte_v = rdata_q[23:16];
      default: byte_v = rdata_q[31:24];
    endcase
    half_v = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      OP_LB:   load_val = {{(DATA_W-8){byte_v[7]}}, byte_v};
      OP_LBU:  load_val = {{(DATA_W-8){1'b0}}, byte_v};
      OP_LH:   load_val = {{(DATA_W-16){half_v[15]}}, half_v};
      OP_LHU:  load_val = {{(DATA_W-16){1'b0}}, half_v};
      OP_LW:   load_val = rdata_q;
      default: load_val = '0;
    endcase
  end

  // Stall, misalign flag and the write-back bus; all forced low during reset
  always_comb begin
    stall_mem    = 1'b0;
    mem_misalign = 1'b0;
    wb_des_addr  = mem_des_addr;
    wb_des_exist = 1'b0;
    wb_des_data  = mem_des_data;
    case (state_q)
      IDLE: begin
        if (go) begin
          stall_mem = 1'b1;
        end else if (is_load || is_store) begin
          mem_misalign = 1'b1;
        end else begin
          wb_des_exist = mem_des_exist;
        end
      end
      BUSY: begin
        stall_mem = 1'b1;
      end
      DONE: begin
        wb_des_addr  = des_addr_q;
        wb_des_data  = load_val;
        wb_des_exist = op_q_is_load && des_exist_q && !mem_err;
      end
      default: ;
    endcase
    if (rst) begin
      stall_mem    = 1'b0;
      mem_misalign = 1'b0;
      wb_des_addr  = '0;
      wb_des_exist = 1'b0;
      wb_des_data  = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard: the expected
// MEM/WB result is queued when an instruction is driven and popped when the
// stage stops stalling.
module tb_mem_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] mem_des_addr;
  logic          mem_des_exist;
  logic [DW-1:0] mem_des_data;
  logic [3:0]    mem_op;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          stall_mem;
  logic          mem_misalign;
  logic          mem_err;
  logic [RW-1:0] wb_des_addr;
  logic          wb_des_exist;
  logic [DW-1:0] wb_des_data;

  mem_stage_if #(.DATA_W(DW)) dm_bus ();

  mem_stage #(
    .DATA_W     (DW),
    .REG_ADDR_W (RW),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_des_addr  (mem_des_addr),
    .mem_des_exist (mem_des_exist),
    .mem_des_data  (mem_des_data),
    .mem_op        (mem_op),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .dm            (dm_bus),
    .stall_mem     (stall_mem),
    .mem_misalign  (mem_misalign),
    .mem_err       (mem_err),
    .wb_des_addr   (wb_des_addr),
    .wb_des_exist  (wb_des_exist),
    .wb_des_data   (wb_des_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] a;
    logic          e;
    logic [DW-1:0] d;
    logic          chk_d;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls;
  int   busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [RW-1:0] da, input logic de, input logic [31:0] dd);
    mem_op        = op;
    mem_addr      = addr;
    mem_wdata     = wdata;
    mem_des_addr  = da;
    mem_des_exist = de;
    mem_des_data  = dd;
  endtask

  // Pop one expected write-back and compare against the bus now
  task automatic check_wb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_wb_exist"}, {31'b0, wb_des_exist}, {31'b0, e.e});
      chk({tag, "_mem_err"}, {31'b0, mem_err}, {31'b0, e.err});
      if (e.chk_d) begin
        chk({tag, "_wb_addr"}, {27'b0, wb_des_addr}, {27'b0, e.a});
        chk({tag, "_wb_data"}, wb_des_data, e.d);
      end
    end
  endtask

  // Run one access already driven in IDLE; ack on BUSY cycle ack_at (0 = never)
  task automatic run_access(input string tag, input int ack_at, input logic [31:0] rdata,
                            input logic ex_we, input logic [31:0] ex_addr, input logic chk_lanes,
                            input logic [3:0] ex_be, input logic [31:0] ex_wdata,
                            output int n_stall, output int n_busy);
    logic done;
    n_stall = 0;
    n_busy  = 0;
    done    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall_mem) begin
        n_stall++;
        chk({tag, "_stall_exist"}, {31'b0, wb_des_exist}, 32'd0);
        if (dm_bus.dm_req) begin
          n_busy++;
          chk({tag, "_we"}, {31'b0, dm_bus.dm_we}, {31'b0, ex_we});
          chk({tag, "_addr"}, dm_bus.dm_addr, ex_addr);
          if (chk_lanes) begin
            chk({tag, "_be"}, {28'b0, dm_bus.dm_be}, {28'b0, ex_be});
            chk({tag, "_wdata"}, dm_bus.dm_wdata, ex_wdata);
          end
          if (n_busy == ack_at) begin
            dm_bus.dm_ack   = 1'b1;
            dm_bus.dm_rdata = rdata;
          end
        end
        @(posedge clk);
        #1;
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = 32'h0;
      end else begin
        done = 1'b1;
        chk({tag, "_done_req"}, {31'b0, dm_bus.dm_req}, 32'd0);
        check_wb(tag);
      end
    end
    chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    dm_bus.dm_ack   = 1'b0;
    dm_bus.dm_rdata = 32'h0;
    rst = 1'b1;
    drive(OP_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);

    // Reset values, with a live pass-through request on the inputs
    #3;
    chk("rst_req", {31'b0, dm_bus.dm_req}, 32'd0);
    chk("rst_we", {31'b0, dm_bus.dm_we}, 32'd0);
    chk("rst_addr", dm_bus.dm_addr, 32'd0);
    chk("rst_be", {28'b0, dm_bus.dm_be}, 32'd0);
    chk("rst_wdata", dm_bus.dm_wdata, 32'd0);
    chk("rst_stall", {31'b0, stall_mem}, 32'd0);
    chk("rst_misalign", {31'b0, mem_misalign}, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    chk("rst_wb_addr", {27'b0, wb_des_addr}, 32'd0);
    chk("rst_wb_exist", {31'b0, wb_des_exist}, 32'd0);
    chk("rst_wb_data", wb_des_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Non-memory op passes straight through
    sb.push_back('{a: 5'd5, e: 1'b1, d: 32'h1234, chk_d: 1'b1, err: 1'b0});
    @(negedge clk);
    chk("pass_stall", {31'b0, stall_mem}, 32'd0);
    check_wb("pass");

    // Op codes 9-15 also behave as none; a stray ack in IDLE is ignored
    @(posedge clk);
    #1;
    drive(4'd12, 32'h104, 32'h0, 5'd3, 1'b1, 32'hCAFE_F00D);
    dm_bus.dm_ack = 1'b1;
    sb.push_back('{a: 5'd3, e: 1'b1, d: 32'hCAFE_F00D, chk_d: 1'b1, err: 1'b0});
    @(negedge clk);
    check_wb("op12");
    @(posedge clk);
    #1 dm_bus.dm_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_req", {31'b0, dm_bus.dm_req}, 32'd0);
    chk("stray_ack_stall", {31'b0, stall_mem}, 32'd0);

    // LB sign-extended from byte 3, ack on third BUSY cycle
    @(posedge clk);
    #1;
    drive(OP_LB, 32'h103, 32'h0, 5'd7, 1'b1, 32'hDEAD);
    sb.push_back('{a: 5'd7, e: 1'b1, d: 32'hFFFF_FF80, chk_d: 1'b1, err: 1'b0});
    run_access("lb", 3, 32'h80FF_0000, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, stalls, busy);
    chk("lb_stalls", 32'(stalls), 32'd4);
    chk("lb_busy", 32'(busy), 32'd3);

    // SH to upper half: lanes 1100, replicated data, no write-back
    @(posedge clk);
    #1;
    drive(OP_SH, 32'h42, 32'h0000_ABCD, 5'd8, 1'b1, 32'h0);
    sb.push_back('{a: 5'd8, e: 1'b0, d: 32'h0, chk_d: 1'b0, err: 1'b0});
    run_access("sh", 1, 32'h0, 1'b1, 32'h40, 1'b1, 4'b1100, 32'hABCD_ABCD, stalls, busy);
    chk("sh_stalls", 32'(stalls), 32'd2);

    // SB to byte 3 and SW full word
    @(posedge clk);
    #1;
    drive(OP_SB, 32'h33, 32'h1234_565A, 5'd9, 1'b1, 32'h0);
    sb.push_back('{a: 5'd9, e: 1'b0, d: 32'h0, chk_d: 1'b0, err: 1'b0});
    run_access("sb", 2, 32'h0, 1'b1, 32'h30, 1'b1, 4'b1000, 32'h5A5A_5A5A, stalls, busy);
    @(posedge clk);
    #1;
    drive(OP_SW, 32'h88, 32'h0BAD_BEEF, 5'd10, 1'b1, 32'h0);
    sb.push_back('{a: 5'd10, e: 1'b0, d: 32'h0, chk_d: 1'b0, err: 1'b0});
    run_access("sw", 1, 32'h0, 1'b1, 32'h88, 1'b1, 4'b1111, 32'h0BAD_BEEF, stalls, busy);

    // Half/byte load extension variants, issued back to back
    @(posedge clk);
    #1;
    drive(OP_LH, 32'h12, 32'h0, 5'd11, 1'b1, 32'h0);
    sb.push_back('{a: 5'd11, e: 1'b1, d: 32'hFFFF_8001, chk_d: 1'b1, err: 1'b0});
    run_access("lh", 1, 32'h8001_7FFF, 1'b0, 32'h10, 1'b0, 4'h0, 32'h0, stalls, busy);
    @(posedge clk);
    #1;
    drive(OP_LHU, 32'h10, 32'h0, 5'd12, 1'b1, 32'h0);
    sb.push_back('{a: 5'd12, e: 1'b1, d: 32'h0000_F00F, chk_d: 1'b1, err: 1'b0});
    run_access("lhu", 2, 32'h1234_F00F, 1'b0, 32'h10, 1'b0, 4'h0, 32'h0, stalls, busy);
    @(posedge clk);
    #1;
    drive(OP_LBU, 32'h21, 32'h0, 5'd13, 1'b0, 32'h0);
    sb.push_back('{a: 5'd13, e: 1'b0, d: 32'h0000_009A, chk_d: 1'b1, err: 1'b0});
    run_access("lbu", 1, 32'h0000_9A00, 1'b0, 32'h20, 1'b0, 4'h0, 32'h0, stalls, busy);

    // Misaligned LW: flag only, no request, no stall
    @(posedge clk);
    #1;
    drive(OP_LW, 32'h6, 32'h0, 5'd9, 1'b1, 32'h77);
    @(negedge clk);
    chk("mis_flag", {31'b0, mem_misalign}, 32'd1);
    chk("mis_stall", {31'b0, stall_mem}, 32'd0);
    chk("mis_exist", {31'b0, wb_des_exist}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mis_req", {31'b0, dm_bus.dm_req}, 32'd0);
    chk("mis_stall2", {31'b0, stall_mem}, 32'd0);

    // Reset while BUSY, then the same LW completes normally
    @(posedge clk);
    #1;
    drive(OP_LW, 32'h200, 32'h0, 5'd14, 1'b1, 32'h0);
    @(negedge clk);
    chk("rb_idle_stall", {31'b0, stall_mem}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rb_busy_req", {31'b0, dm_bus.dm_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rb_req", {31'b0, dm_bus.dm_req}, 32'd0);
    chk("rb_stall", {31'b0, stall_mem}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.push_back('{a: 5'd14, e: 1'b1, d: 32'h1234_5678, chk_d: 1'b1, err: 1'b0});
    run_access("lw", 2, 32'h1234_5678, 1'b0, 32'h200, 1'b0, 4'h0, 32'h0, stalls, busy);
    chk("lw_stalls", 32'(stalls), 32'd3);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TIMEOUT BUSY cycles with a one-cycle mem_err
    @(posedge clk);
    #1;
    drive(OP_LW, 32'h80, 32'h0, 5'd15, 1'b1, 32'h0);
    sb.push_back('{a: 5'd15, e: 1'b0, d: 32'h0, chk_d: 1'b0, err: 1'b1});
    run_access("to", 0, 32'h0, 1'b0, 32'h80, 1'b0, 4'h0, 32'h0, stalls, busy);
    chk("to_busy", 32'(busy), 32'd4);
    @(posedge clk);
    #1;
    drive(OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    chk("to_err_once", {31'b0, mem_err}, 32'd0);
    @(posedge clk);
    #1 dm_bus.dm_ack = 1'b0;
    // Ack on the last allowed cycle wins over the timeout
    drive(OP_LW, 32'h84, 32'h0, 5'd16, 1'b1, 32'h0);
    sb.push_back('{a: 5'd16, e: 1'b1, d: 32'h5555_AAAA, chk_d: 1'b1, err: 1'b0});
    run_access("to_ack", 4, 32'h5555_AAAA, 1'b0, 32'h84, 1'b0, 4'h0, 32'h0, stalls, busy);
    chk("to_ack_busy", 32'(busy), 32'd4);
`else
    // Without the timeout, BUSY waits as long as the memory takes
    @(posedge clk);
    #1;
    drive(OP_LW, 32'h80, 32'h0, 5'd15, 1'b1, 32'h0);
    sb.push_back('{a: 5'd15, e: 1'b1, d: 32'hA5A5_0F0F, chk_d: 1'b1, err: 1'b0});
    run_access("slow", 12, 32'hA5A5_0F0F, 1'b0, 32'h80, 1'b0, 4'h0, 32'h0, stalls, busy);
    chk("slow_busy", 32'(busy), 32'd12);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
